// File: rtl/register_rename.sv
// ---------------------------------------------------------------------------
// register_rename
//   Two-wide register rename stage. Maps the architectural sources of the
//   decoded uOP pair to physical registers through a speculative RAT and
//   allocates new physical destinations from a circular free list. The
//   renamed pair is presented to dispatch from a one-cycle output register.
//   A committed RAT and a committed free-list head are kept alongside the
//   speculative state, so a flush restores rename state in a single cycle.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   flush                 drop input, restore speculative state from committed
//   pause                 downstream stall: hold the output register
//   stall_req             input pair cannot be accepted (free list too short)
//   in_valid/in_wen       per-uOP valid and destination-write flags (uOP0 older)
//   in_asrcA/B, in_adst   architectural sources / destination per uOP
//   out_valid/out_wen     renamed uOP valid / effective write enable
//   out_psrcA/B           physical sources
//   out_pdst, out_pold    new physical destination / previous mapping of adst
//   cm_valid/cm_wen       commit slots (slot0 older), destination-write flag
//   cm_adst/pdst/pold     committed mapping; pold returns to the free list
// ---------------------------------------------------------------------------
module register_rename #(
    parameter int NUM_AREG = 32,
    parameter int NUM_PREG = 64,
    parameter int PW       = $clog2(NUM_PREG),
    parameter int AW       = $clog2(NUM_AREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 pause,
    output logic                 stall_req,
    input  logic [1:0]           in_valid,
    input  logic [1:0]           in_wen,
    input  logic [1:0][AW-1:0]   in_asrcA,
    input  logic [1:0][AW-1:0]   in_asrcB,
    input  logic [1:0][AW-1:0]   in_adst,
    output logic [1:0]           out_valid,
    output logic [1:0]           out_wen,
    output logic [1:0][PW-1:0]   out_psrcA,
    output logic [1:0][PW-1:0]   out_psrcB,
    output logic [1:0][PW-1:0]   out_pdst,
    output logic [1:0][PW-1:0]   out_pold,
    input  logic [1:0]           cm_valid,
    input  logic [1:0]           cm_wen,
    input  logic [1:0][AW-1:0]   cm_adst,
    input  logic [1:0][PW-1:0]   cm_pdst,
    input  logic [1:0][PW-1:0]   cm_pold
);

    localparam int FL_DEPTH = NUM_PREG - NUM_AREG;
    localparam int LW       = $clog2(FL_DEPTH);
    localparam int PTRW     = LW + 1;

    // Number of set bits in a two-bit vector.
    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    logic [PW-1:0]   spec_rat_r [NUM_AREG];
    logic [PW-1:0]   cm_rat_r   [NUM_AREG];
    logic [PW-1:0]   cm_rat_nx_s[NUM_AREG];
    logic [PW-1:0]   fl_r       [FL_DEPTH];
    logic [PTRW-1:0] head_r;
    logic [PTRW-1:0] tail_r;
    logic [PTRW-1:0] cm_head_r;

    logic [1:0]          ewen_s;
    logic [1:0]          need_s;
    logic [PTRW-1:0]     count_s;
    logic                accept_s;
    logic [LW-1:0]       hidx0_s;
    logic [LW-1:0]       hidx1_s;
    logic [PW-1:0]       alloc0_s;
    logic [PW-1:0]       alloc1_s;
    logic [1:0][PW-1:0]  psrca_s;
    logic [1:0][PW-1:0]  psrcb_s;
    logic [1:0][PW-1:0]  pdst_s;
    logic [1:0][PW-1:0]  pold_s;
    logic [1:0]          cwen_s;
    logic [1:0]          ncm_s;
    logic [PTRW-1:0]     cm_head_nx_s;
    logic [LW-1:0]       tidx0_s;
    logic [LW-1:0]       tidx1_s;

    // Rename the incoming pair: allocation, source lookup, intra-pair bypass.
    always_comb begin
        ewen_s[0] = in_valid[0] & in_wen[0] & (in_adst[0] != {AW{1'b0}});
        ewen_s[1] = in_valid[1] & in_wen[1] & (in_adst[1] != {AW{1'b0}});
        need_s    = pop2(ewen_s);
        // tail - head is the occupancy; the extra wrap bit separates full from empty
        count_s   = tail_r - head_r;
        accept_s  = (|in_valid) && !pause && !flush && (count_s >= PTRW'(need_s));
        stall_req = (|in_valid) && (count_s < PTRW'(need_s));

        hidx0_s  = head_r[LW-1:0];
        hidx1_s  = hidx0_s + LW'(1);
        alloc0_s = fl_r[hidx0_s];
        alloc1_s = fl_r[hidx1_s];

        pdst_s[0] = ewen_s[0] ? alloc0_s : {PW{1'b0}};
        // uOP1 takes the head entry itself when uOP0 allocates nothing
        pdst_s[1] = ewen_s[1] ? (ewen_s[0] ? alloc1_s : alloc0_s) : {PW{1'b0}};

        psrca_s[0] = (in_asrcA[0] == {AW{1'b0}}) ? {PW{1'b0}} : spec_rat_r[in_asrcA[0]];
        psrcb_s[0] = (in_asrcB[0] == {AW{1'b0}}) ? {PW{1'b0}} : spec_rat_r[in_asrcB[0]];
        pold_s[0]  = ewen_s[0] ? spec_rat_r[in_adst[0]] : {PW{1'b0}};

        // uOP1 must see uOP0's new mapping, which is not yet in the RAT
        psrca_s[1] = (in_asrcA[1] == {AW{1'b0}}) ? {PW{1'b0}} :
                     (ewen_s[0] && (in_asrcA[1] == in_adst[0])) ? pdst_s[0] :
                     spec_rat_r[in_asrcA[1]];
        psrcb_s[1] = (in_asrcB[1] == {AW{1'b0}}) ? {PW{1'b0}} :
                     (ewen_s[0] && (in_asrcB[1] == in_adst[0])) ? pdst_s[0] :
                     spec_rat_r[in_asrcB[1]];
        pold_s[1]  = !ewen_s[1] ? {PW{1'b0}} :
                     (ewen_s[0] && (in_adst[1] == in_adst[0])) ? pdst_s[0] :
                     spec_rat_r[in_adst[1]];
    end

    // Commit bookkeeping: next committed RAT, committed head and free-list tail slots.
    always_comb begin
        cwen_s[0]    = cm_valid[0] & cm_wen[0];
        cwen_s[1]    = cm_valid[1] & cm_wen[1];
        ncm_s        = pop2(cwen_s);
        cm_head_nx_s = cm_head_r + PTRW'(ncm_s);
        tidx0_s      = tail_r[LW-1:0];
        tidx1_s      = tidx0_s + LW'(cwen_s[0]);
        // areg 0 stays hard-wired even if a commit names it
        cm_rat_nx_s[0] = cm_rat_r[0];
        for (int i = 1; i < NUM_AREG; i++) begin
            cm_rat_nx_s[i] = (cwen_s[1] && (cm_adst[1] == AW'(i))) ? cm_pdst[1] :
                             (cwen_s[0] && (cm_adst[0] == AW'(i))) ? cm_pdst[0] :
                             cm_rat_r[i];
        end
    end

    // Committed RAT tracks retired mappings; commits apply even during flush/pause.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_AREG; i++) cm_rat_r[i] <= PW'(i);
        end else begin
            for (int i = 0; i < NUM_AREG; i++) cm_rat_r[i] <= cm_rat_nx_s[i];
        end
    end

    // Speculative RAT: restored on flush, updated by accepted pairs (uOP1 wins).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_AREG; i++) spec_rat_r[i] <= PW'(i);
        end else if (flush) begin
            for (int i = 0; i < NUM_AREG; i++) spec_rat_r[i] <= cm_rat_nx_s[i];
        end else if (accept_s) begin
            if (ewen_s[0]) spec_rat_r[in_adst[0]] <= pdst_s[0];
            if (ewen_s[1]) spec_rat_r[in_adst[1]] <= pdst_s[1];
        end
    end

    // Free list storage and tail: freed old mappings are appended, slot0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) fl_r[i] <= PW'(NUM_AREG + i);
            // index 0 with the wrap bit set: list starts full
            tail_r <= {1'b1, {LW{1'b0}}};
        end else begin
            if (cwen_s[0]) fl_r[tidx0_s] <= cm_pold[0];
            if (cwen_s[1]) fl_r[tidx1_s] <= cm_pold[1];
            tail_r <= tail_r + PTRW'(ncm_s);
        end
    end

    // Speculative and committed heads; flush rewinds to the post-commit committed head.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r    <= {PTRW{1'b0}};
            cm_head_r <= {PTRW{1'b0}};
        end else begin
            cm_head_r <= cm_head_nx_s;
            if (flush) begin
                head_r <= cm_head_nx_s;
            end else if (accept_s) begin
                head_r <= head_r + PTRW'(need_s);
            end
        end
    end

    // Output register to dispatch: load on accept, hold on pause, bubble otherwise.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 2'b00;
            out_wen   <= 2'b00;
            out_psrcA <= {2*PW{1'b0}};
            out_psrcB <= {2*PW{1'b0}};
            out_pdst  <= {2*PW{1'b0}};
            out_pold  <= {2*PW{1'b0}};
        end else if (pause) begin
            out_valid <= out_valid;
        end else if (accept_s) begin
            out_valid <= in_valid;
            out_wen   <= ewen_s;
            out_psrcA <= psrca_s;
            out_psrcB <= psrcb_s;
            out_pdst  <= pdst_s;
            out_pold  <= pold_s;
        end else begin
            out_valid <= 2'b00;
            out_wen   <= 2'b00;
            out_psrcA <= {2*PW{1'b0}};
            out_psrcB <= {2*PW{1'b0}};
            out_pdst  <= {2*PW{1'b0}};
            out_pold  <= {2*PW{1'b0}};
        end
    end

endmodule

// File: tb/tb_register_rename.sv
// ---------------------------------------------------------------------------
// tb_register_rename
//   Self-checking bench for register_rename. A reference model (arrays for the
//   RATs, a queue for the free list, a queue of in-flight writers) predicts
//   each cycle's output register contents; predictions go into a scoreboard
//   queue that an independent monitor pops and compares after every clock.
// ---------------------------------------------------------------------------
module tb_register_rename;

    localparam int PW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, flush, pause, stall_req;
    logic [1:0]       in_valid, in_wen;
    logic [1:0][4:0]  in_asrcA, in_asrcB, in_adst;
    logic [1:0]       out_valid, out_wen;
    logic [1:0][5:0]  out_psrcA, out_psrcB, out_pdst, out_pold;
    logic [1:0]       cm_valid, cm_wen;
    logic [1:0][4:0]  cm_adst;
    logic [1:0][5:0]  cm_pdst, cm_pold;

    register_rename dut (
        .clk(clk), .rst(rst), .flush(flush), .pause(pause), .stall_req(stall_req),
        .in_valid(in_valid), .in_wen(in_wen), .in_asrcA(in_asrcA), .in_asrcB(in_asrcB),
        .in_adst(in_adst), .out_valid(out_valid), .out_wen(out_wen),
        .out_psrcA(out_psrcA), .out_psrcB(out_psrcB), .out_pdst(out_pdst), .out_pold(out_pold),
        .cm_valid(cm_valid), .cm_wen(cm_wen), .cm_adst(cm_adst), .cm_pdst(cm_pdst),
        .cm_pold(cm_pold)
    );

    typedef struct packed {
        logic [1:0]      v;
        logic [1:0]      wen;
        logic [1:0][5:0] psa;
        logic [1:0][5:0] psb;
        logic [1:0][5:0] pd;
        logic [1:0][5:0] po;
    } exp_t;

    typedef struct {
        int adst;
        int pdst;
        int pold;
    } rob_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last_exp;
    bit   mon_en = 1'b0;

    // reference model state
    int   spec_rat[32];
    int   cm_rat[32];
    int   fq[$];
    rob_t rob[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_cm(input int s, input int k);
        cm_valid[s] = 1'b1;
        cm_wen[s]   = 1'b1;
        cm_adst[s]  = 5'(rob[k].adst);
        cm_pdst[s]  = 6'(rob[k].pdst);
        cm_pold[s]  = 6'(rob[k].pold);
    endtask

    // a committing uOP that wrote nothing: its fields must be ignored
    task automatic set_junk(input int s);
        cm_valid[s] = 1'b1;
        cm_wen[s]   = 1'b0;
        cm_adst[s]  = 5'($urandom_range(0, 31));
        cm_pdst[s]  = 6'($urandom_range(0, 63));
        cm_pold[s]  = 6'($urandom_range(0, 63));
    endtask

    // One cycle: drive inputs and commits, check stall_req, advance the model,
    // push the expected output-register contents for the coming edge.
    task automatic step(input logic [1:0] v, input logic [1:0] w,
                        input logic [1:0][4:0] a, input logic [1:0][4:0] b,
                        input logic [1:0][4:0] d, input bit p, input bit f,
                        input int ncm, input bit junk);
        exp_t e;
        int   need;
        int   nc;
        bit   acc;
        bit   exp_stall;
        rob_t r;
        e = '0;
        @(negedge clk);
        in_valid = v; in_wen = w; in_asrcA = a; in_asrcB = b; in_adst = d;
        pause = p; flush = f;
        cm_valid = 2'b00; cm_wen = 2'b00; cm_adst = 10'd0; cm_pdst = 12'd0; cm_pold = 12'd0;
        nc = (ncm < rob.size()) ? ncm : rob.size();
        if (nc == 2) begin
            set_cm(0, 0); set_cm(1, 1);
        end else if (nc == 1) begin
            if (junk) begin set_junk(0); set_cm(1, 0); end
            else set_cm(0, 0);
        end else if (junk) begin
            set_junk(1);
        end
        need = 0;
        for (int s = 0; s < 2; s++) if (v[s] && w[s] && d[s] != 5'd0) need++;
        exp_stall = (v != 2'b00) && (fq.size() < need);
        acc       = (v != 2'b00) && !p && !f && (fq.size() >= need);
        #1;
        chk("stall_req", int'(stall_req), int'(exp_stall));
        for (int k = 0; k < nc; k++) begin
            r = rob.pop_front();
            cm_rat[r.adst] = r.pdst;
            fq.push_back(r.pold);
        end
        if (f) begin
            spec_rat = cm_rat;
            for (int k = rob.size() - 1; k >= 0; k--) fq.push_front(rob[k].pdst);
            rob.delete();
        end else if (acc) begin
            for (int s = 0; s < 2; s++) begin
                if (v[s]) begin
                    e.v[s]   = 1'b1;
                    e.psa[s] = (a[s] == 5'd0) ? 6'd0 : 6'(spec_rat[a[s]]);
                    e.psb[s] = (b[s] == 5'd0) ? 6'd0 : 6'(spec_rat[b[s]]);
                    if (w[s] && d[s] != 5'd0) begin
                        r.adst = int'(d[s]);
                        r.pdst = fq.pop_front();
                        r.pold = spec_rat[d[s]];
                        spec_rat[d[s]] = r.pdst;
                        rob.push_back(r);
                        e.wen[s] = 1'b1;
                        e.pd[s]  = 6'(r.pdst);
                        e.po[s]  = 6'(r.pold);
                    end
                end
            end
        end else if (p) begin
            e = last_exp;
        end
        last_exp = e;
        sb.push_back(e);
        mon_en = 1'b1;
    endtask

    task automatic wpair(input int d0, input int a0, input int b0,
                         input int d1, input int a1, input int b1);
        step(2'b11, 2'b11, {5'(a1), 5'(a0)}, {5'(b1), 5'(b0)}, {5'(d1), 5'(d0)},
             1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic idle(input int ncm, input bit f);
        step(2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 1'b0, f, ncm, 1'b0);
    endtask

    // Monitor: one expected entry per clock, compared right after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_valid", int'(out_valid), int'(e.v));
                    for (int s = 0; s < 2; s++) begin
                        if (e.v[s]) begin
                            chk($sformatf("out_wen%0d", s),   int'(out_wen[s]),   int'(e.wen[s]));
                            chk($sformatf("out_psrcA%0d", s), int'(out_psrcA[s]), int'(e.psa[s]));
                            chk($sformatf("out_psrcB%0d", s), int'(out_psrcB[s]), int'(e.psb[s]));
                            chk($sformatf("out_pdst%0d", s),  int'(out_pdst[s]),  int'(e.pd[s]));
                            chk($sformatf("out_pold%0d", s),  int'(out_pold[s]),  int'(e.po[s]));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int   sv0, sv1;
        logic [1:0][4:0] ra, rb, rd;
        rst = 1'b1; flush = 1'b0; pause = 1'b0;
        in_valid = 2'b00; in_wen = 2'b00; in_asrcA = 10'd0; in_asrcB = 10'd0; in_adst = 10'd0;
        cm_valid = 2'b00; cm_wen = 2'b00; cm_adst = 10'd0; cm_pdst = 12'd0; cm_pold = 12'd0;
        for (int i = 0; i < 32; i++) begin spec_rat[i] = i; cm_rat[i] = i; fq.push_back(32 + i); end
        last_exp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_pdst", int'(out_pdst), 0);
        chk("rst_out_pold", int'(out_pold), 0);
        chk("rst_stall_req", int'(stall_req), 0);
        rst = 1'b0;

        // r3 <- r1,r2 ; r4 <- r3,r3
        wpair(3, 1, 2, 4, 3, 3);
        @(posedge clk); #2;
        chk("t1_pdst0", int'(out_pdst[0]), 32);
        chk("t1_pdst1", int'(out_pdst[1]), 33);
        chk("t1_psrcA1", int'(out_psrcA[1]), 32);
        chk("t1_psrcB1", int'(out_psrcB[1]), 32);
        chk("t1_pold0", int'(out_pold[0]), 3);
        chk("t1_pold1", int'(out_pold[1]), 4);

        // r5 <- r6,r7 ; r5 <- r5,r0, then read r5
        wpair(5, 6, 7, 5, 5, 0);
        @(posedge clk); #2;
        chk("t2_psrcA1", int'(out_psrcA[1]), 34);
        chk("t2_psrcB1", int'(out_psrcB[1]), 0);
        chk("t2_pold1", int'(out_pold[1]), 34);
        chk("t2_pdst1", int'(out_pdst[1]), 35);
        step(2'b01, 2'b00, {5'd0, 5'd5}, {5'd0, 5'd5}, 10'd0, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk); #2;
        chk("t2_read_r5", int'(out_psrcA[0]), 35);

        // drain the free list, then stall on a writing pair
        while (fq.size() >= 2) wpair($urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                                     $urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31));
        step(2'b11, 2'b11, {5'd1, 5'd2}, {5'd3, 5'd4}, {5'd9, 5'd8}, 1'b0, 1'b0, 0, 1'b0);
        chk("full_stall", int'(stall_req), 1);
        // adst 0 writers need no allocation even with an empty list
        step(2'b11, 2'b11, {5'd1, 5'd2}, {5'd3, 5'd4}, 10'd0, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk); #2;
        chk("z_out_wen", int'(out_wen), 0);
        chk("z_out_pdst", int'(out_pdst), 0);
        sv0 = rob[0].pold; sv1 = rob[1].pold;
        step(2'b11, 2'b11, {5'd1, 5'd2}, {5'd3, 5'd4}, {5'd9, 5'd8}, 1'b0, 1'b0, 2, 1'b0);
        step(2'b11, 2'b11, {5'd1, 5'd2}, {5'd3, 5'd4}, {5'd9, 5'd8}, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk); #2;
        chk("refill_pdst0", int'(out_pdst[0]), sv0);
        chk("refill_pdst1", int'(out_pdst[1]), sv1);

        // retire everything, rename 3 pairs, commit the first, flush
        while (rob.size() > 0) idle(2, 1'b0);
        wpair(3, 1, 2, 4, 1, 2);
        wpair(3, 3, 4, 4, 3, 4);
        wpair(3, 4, 3, 4, 4, 3);
        sv0 = rob[0].pdst; sv1 = rob[1].pdst;
        idle(2, 1'b1);
        step(2'b01, 2'b00, {5'd0, 5'd3}, {5'd0, 5'd4}, 10'd0, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk); #2;
        chk("flush_r3", int'(out_psrcA[0]), sv0);
        chk("flush_r4", int'(out_psrcB[0]), sv1);

        // pause held with new input: output holds
        wpair(6, 1, 2, 7, 6, 3);
        repeat (3) step(2'b11, 2'b11, {5'd8, 5'd9}, {5'd7, 5'd6}, {5'd11, 5'd10}, 1'b1, 1'b0, 0, 1'b0);
        idle(0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int s = 0; s < 2; s++) begin
                ra[s] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                rb[s] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                rd[s] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            end
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ra, rb, rd,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        repeat (3) idle(0, 1'b0);
        @(posedge clk); #2;
        mon_en = 1'b0;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
